// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: CPU (m0) / ADC DMA (m1) arbiter for the single-port word SRAM.
// One SRAM access per grant; each transaction walks IDLE -> ACCESS -> RESP.
module soc_mem_arbiter #(
    parameter int MEM_WORDS  = 1024,
    parameter int ADDR_W     = 10,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic              err,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, state_n;
    logic grant, grant_n;
    logic last, last_n;
    logic oor, oor_n;
    logic rd, rd_n;
    logic en_n;
    logic [3:0] we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0] wdata_n;

    logic pick1;
    logic [31:0] req_addr;
    logic [3:0] req_strb;
    logic in_range;
    logic resp;
    logic [31:0] rdata_mux;
    logic unused_ok;

    // m1 wins when it is alone, or on a tie when m0 was served last (RR only)
    assign pick1 = m1_valid & (~m0_valid | (~FIXED_PRIO & ~last));
    assign req_addr = pick1 ? m1_addr : m0_addr;
    assign req_strb = pick1 ? m1_wstrb : m0_wstrb;
    assign in_range = req_addr[31:2] < 30'(MEM_WORDS);
    assign unused_ok = ^req_addr[1:0];

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last;
        oor_n   = oor;
        rd_n    = rd;
        en_n    = 1'b0;
        we_n    = 4'b0000;
        addr_n  = sram_addr;
        wdata_n = sram_wdata;
        unique case (state)
            IDLE: begin
                if (m0_valid | m1_valid) begin
                    state_n = ACCESS;
                    grant_n = pick1;
                    last_n  = pick1;
                    oor_n   = ~in_range;
                    rd_n    = (req_strb == 4'b0000);
                    en_n    = in_range;
                    we_n    = in_range ? req_strb : 4'b0000;
                    addr_n  = req_addr[ADDR_W+1:2];
                    wdata_n = pick1 ? m1_wdata : m0_wdata;
                end
            end
            ACCESS:  state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last       <= 1'b1;
            oor        <= 1'b0;
            rd         <= 1'b0;
            sram_en    <= 1'b0;
            sram_we    <= 4'b0000;
            sram_addr  <= '0;
            sram_wdata <= 32'd0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last       <= last_n;
            oor        <= oor_n;
            rd         <= rd_n;
            sram_en    <= en_n;
            sram_we    <= we_n;
            sram_addr  <= addr_n;
            sram_wdata <= wdata_n;
        end
    end

    // SRAM data is only meaningful for an in-range read in RESP
    assign resp      = (state == RESP);
    assign rdata_mux = (rd & ~oor) ? sram_rdata : 32'd0;
    assign m0_ready  = resp & ~grant;
    assign m1_ready  = resp & grant;
    assign m0_rdata  = m0_ready ? rdata_mux : 32'd0;
    assign m1_rdata  = m1_ready ? rdata_mux : 32'd0;
    assign err       = resp & oor;

endmodule
